bellek_erisim: RTL and testbench

//  Memory-access stage directly downstream of the execute (ALU) stage. Takes the

---
 rtl/bellek_erisim.sv | 198 +++++++++++++++++++
 tb/tb_bellek_erisim.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bellek_erisim.sv
// bellek_erisim: memory-access stage between execute and write-back.
// Issues one data-memory transaction per load/store; other results pass through one register.
module bellek_erisim #(
  parameter int ZAMAN_ASIMI = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        giris_gecerli_i,
  input  logic [5:0]  islem_kodu_i,
  input  logic [31:0] sonuc_i,
  input  logic [31:0] yazmac_degeri2_i,
  input  logic [4:0]  hedef_yazmac_i,
  input  logic        yazmac_yaz_i,
  output logic        durdur_o,
  output logic        bellek_istek_o,
  output logic        bellek_yaz_o,
  output logic [31:0] bellek_adres_o,
  output logic [31:0] bellek_veri_o,
  output logic [3:0]  bellek_maske_o,
  input  logic        bellek_hazir_i,
  input  logic [31:0] bellek_veri_i,
  output logic        cikis_gecerli_o,
  output logic [31:0] cikis_veri_o,
  output logic [4:0]  cikis_yazmac_o,
  output logic        cikis_yaz_o,
  output logic        hizasiz_o,
  output logic        zaman_asimi_o
);

  // Memory opcode encodings; these must match the decoder's operation table.
  localparam logic [5:0] MEM_LB  = 6'h20;
  localparam logic [5:0] MEM_LH  = 6'h21;
  localparam logic [5:0] MEM_LW  = 6'h22;
  localparam logic [5:0] MEM_LBU = 6'h23;
  localparam logic [5:0] MEM_LHU = 6'h24;
  localparam logic [5:0] MEM_SB  = 6'h25;
  localparam logic [5:0] MEM_SH  = 6'h26;
  localparam logic [5:0] MEM_SW  = 6'h27;

  localparam int CW = $clog2(ZAMAN_ASIMI + 1);
  localparam logic [CW-1:0] LIMIT = CW'(ZAMAN_ASIMI - 1);

  typedef enum logic {BOSTA, ISTEK} durum_t;

  durum_t        state, state_next;
  logic [CW-1:0] count;
  logic [5:0]    op_hold;
  logic [1:0]    addr_low;
  logic [4:0]    rd_hold;
  logic          is_mem, is_store, aligned, accept, start, done, expired;
  logic [3:0]    mask_calc;
  logic [31:0]   store_data, load_data;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;

  always_comb begin
    is_mem     = 1'b0;
    is_store   = 1'b0;
    aligned    = 1'b1;
    mask_calc  = 4'b0000;
    store_data = 32'b0;
    case (islem_kodu_i)
      MEM_LB, MEM_LBU: is_mem = 1'b1;
      MEM_LH, MEM_LHU: begin
        is_mem  = 1'b1;
        aligned = ~sonuc_i[0];
      end
      MEM_LW: begin
        is_mem  = 1'b1;
        aligned = (sonuc_i[1:0] == 2'b00);
      end
      MEM_SB: begin
        is_mem     = 1'b1;
        is_store   = 1'b1;
        mask_calc  = 4'b0001 << sonuc_i[1:0];
        store_data = {4{yazmac_degeri2_i[7:0]}};
      end
      MEM_SH: begin
        is_mem     = 1'b1;
        is_store   = 1'b1;
        aligned    = ~sonuc_i[0];
        mask_calc  = 4'b0011 << sonuc_i[1:0];
        store_data = {2{yazmac_degeri2_i[15:0]}};
      end
      MEM_SW: begin
        is_mem     = 1'b1;
        is_store   = 1'b1;
        aligned    = (sonuc_i[1:0] == 2'b00);
        mask_calc  = 4'b1111;
        store_data = yazmac_degeri2_i;
      end
      default: ;
    endcase
  end

  assign accept  = giris_gecerli_i && (state == BOSTA);
  assign start   = accept && is_mem && aligned;
  assign done    = (state == ISTEK) && bellek_hazir_i;
  assign expired = (state == ISTEK) && !bellek_hazir_i && (count == LIMIT);

  // Lane selection uses the address bits captured at accept time.
  always_comb begin
    load_byte = bellek_veri_i[{addr_low, 3'b000} +: 8];
    load_half = bellek_veri_i[{addr_low[1], 4'b0000} +: 16];
    case (op_hold)
      MEM_LB:  load_data = {{24{load_byte[7]}}, load_byte};
      MEM_LBU: load_data = {24'b0, load_byte};
      MEM_LH:  load_data = {{16{load_half[15]}}, load_half};
      MEM_LHU: load_data = {16'b0, load_half};
      MEM_LW:  load_data = bellek_veri_i;
      default: load_data = 32'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= BOSTA;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      BOSTA: if (start) state_next = ISTEK;
      ISTEK: if (bellek_hazir_i || (count == LIMIT)) state_next = BOSTA;
      default: state_next = BOSTA;
    endcase
  end

  always_comb begin
    durdur_o = (state != BOSTA);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)                              count <= '0;
    else if (start)                          count <= '0;
    else if (state == ISTEK && !bellek_hazir_i) count <= count + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bellek_istek_o  <= 1'b0;
      bellek_yaz_o    <= 1'b0;
      bellek_adres_o  <= 32'b0;
      bellek_veri_o   <= 32'b0;
      bellek_maske_o  <= 4'b0;
      cikis_gecerli_o <= 1'b0;
      cikis_veri_o    <= 32'b0;
      cikis_yazmac_o  <= 5'b0;
      cikis_yaz_o     <= 1'b0;
      hizasiz_o       <= 1'b0;
      zaman_asimi_o   <= 1'b0;
      op_hold         <= 6'b0;
      addr_low        <= 2'b0;
      rd_hold         <= 5'b0;
    end else begin
      cikis_gecerli_o <= 1'b0;
      cikis_yaz_o     <= 1'b0;
      hizasiz_o       <= 1'b0;
      zaman_asimi_o   <= 1'b0;
      if (accept && !is_mem) begin
        cikis_gecerli_o <= 1'b1;
        cikis_veri_o    <= sonuc_i;
        cikis_yazmac_o  <= hedef_yazmac_i;
        cikis_yaz_o     <= yazmac_yaz_i && (hedef_yazmac_i != 5'd0);
      end else if (accept && !aligned) begin
        cikis_gecerli_o <= 1'b1;
        cikis_veri_o    <= 32'b0;
        cikis_yazmac_o  <= hedef_yazmac_i;
        hizasiz_o       <= 1'b1;
      end else if (start) begin
        bellek_istek_o <= 1'b1;
        bellek_yaz_o   <= is_store;
        bellek_adres_o <= {sonuc_i[31:2], 2'b00};
        bellek_veri_o  <= store_data;
        bellek_maske_o <= mask_calc;
        op_hold        <= islem_kodu_i;
        addr_low       <= sonuc_i[1:0];
        rd_hold        <= hedef_yazmac_i;
      end else if (done || expired) begin
        bellek_istek_o  <= 1'b0;
        bellek_yaz_o    <= 1'b0;
        bellek_adres_o  <= 32'b0;
        bellek_veri_o   <= 32'b0;
        bellek_maske_o  <= 4'b0;
        cikis_gecerli_o <= 1'b1;
        cikis_yazmac_o  <= rd_hold;
        zaman_asimi_o   <= expired;
        if (done && !bellek_yaz_o) begin
          cikis_veri_o <= load_data;
          cikis_yaz_o  <= (rd_hold != 5'd0);
        end else begin
          cikis_veri_o <= 32'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bellek_erisim.sv
// tb_bellek_erisim: randomized and directed checks of bellek_erisim against a
// transaction-level model of the memory-access stage.
module tb_bellek_erisim;

  localparam int ZA = 4;

  localparam logic [5:0] ALU_ADD = 6'h01;
  localparam logic [5:0] ALU_XOR = 6'h05;
  localparam logic [5:0] ALU_SLL = 6'h09;
  localparam logic [5:0] MEM_LB  = 6'h20;
  localparam logic [5:0] MEM_LH  = 6'h21;
  localparam logic [5:0] MEM_LW  = 6'h22;
  localparam logic [5:0] MEM_LBU = 6'h23;
  localparam logic [5:0] MEM_LHU = 6'h24;
  localparam logic [5:0] MEM_SB  = 6'h25;
  localparam logic [5:0] MEM_SH  = 6'h26;
  localparam logic [5:0] MEM_SW  = 6'h27;

  logic        clk, rst;
  logic        giris_gecerli, yazmac_yaz, durdur, bellek_istek, bellek_yaz, bellek_hazir;
  logic [5:0]  islem_kodu;
  logic [31:0] sonuc, yazmac_degeri2, bellek_adres, bellek_veri_out, bellek_veri_in, cikis_veri;
  logic [4:0]  hedef_yazmac, cikis_yazmac;
  logic [3:0]  bellek_maske;
  logic        cikis_gecerli, cikis_yaz, hizasiz, zaman_asimi;

  int checks = 0;
  int passes = 0;

  bellek_erisim #(.ZAMAN_ASIMI(ZA)) dut (
    .clk_i(clk), .rst_i(rst),
    .giris_gecerli_i(giris_gecerli), .islem_kodu_i(islem_kodu), .sonuc_i(sonuc),
    .yazmac_degeri2_i(yazmac_degeri2), .hedef_yazmac_i(hedef_yazmac), .yazmac_yaz_i(yazmac_yaz),
    .durdur_o(durdur), .bellek_istek_o(bellek_istek), .bellek_yaz_o(bellek_yaz),
    .bellek_adres_o(bellek_adres), .bellek_veri_o(bellek_veri_out), .bellek_maske_o(bellek_maske),
    .bellek_hazir_i(bellek_hazir), .bellek_veri_i(bellek_veri_in),
    .cikis_gecerli_o(cikis_gecerli), .cikis_veri_o(cikis_veri), .cikis_yazmac_o(cikis_yazmac),
    .cikis_yaz_o(cikis_yaz), .hizasiz_o(hizasiz), .zaman_asimi_o(zaman_asimi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes, 0 for non-memory operations.
  function automatic int accessSize(input logic [5:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  function automatic bit isStore(input logic [5:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> (8 * int'(addr % 4)));
    h = 16'(word >> (16 * int'((addr % 4) / 2)));
    case (op)
      MEM_LB:  return 32'(int'($signed(b)));
      MEM_LBU: return 32'(b);
      MEM_LH:  return 32'(int'($signed(h)));
      MEM_LHU: return 32'(h);
      default: return word;
    endcase
  endfunction

  // One operation end to end; lat = cycles from accept to the cycle memory answers.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                               input logic [4:0] rd, input logic wr, input int lat, input logic [31:0] word);
    int          sz, n, n_exp;
    bit          timeout;
    logic [3:0]  exp_mask;
    logic [31:0] exp_data;
    sz = accessSize(op);
    checkOutput("durdur_idle", 32'(durdur), 32'd0);
    giris_gecerli  = 1'b1;
    islem_kodu     = op;
    sonuc          = addr;
    yazmac_degeri2 = rs2;
    hedef_yazmac   = rd;
    yazmac_yaz     = wr;
    bellek_hazir   = 1'($urandom_range(0, 1));
    bellek_veri_in = $urandom;
    tick();
    giris_gecerli = 1'b0;
    bellek_hazir  = 1'b0;
    if (sz == 0) begin
      checkOutput("alu_gecerli", 32'(cikis_gecerli), 32'd1);
      checkOutput("alu_veri", cikis_veri, addr);
      checkOutput("alu_yazmac", 32'(cikis_yazmac), 32'(rd));
      checkOutput("alu_yaz", 32'(cikis_yaz), 32'(wr && rd != 0));
      checkOutput("alu_flags", {30'd0, hizasiz, zaman_asimi}, 32'd0);
      checkOutput("alu_durdur", 32'(durdur), 32'd0);
    end else if (addr % sz != 0) begin
      checkOutput("hiz_gecerli", 32'(cikis_gecerli), 32'd1);
      checkOutput("hiz_flag", 32'(hizasiz), 32'd1);
      checkOutput("hiz_yaz", 32'(cikis_yaz), 32'd0);
      checkOutput("hiz_istek", 32'(bellek_istek), 32'd0);
      checkOutput("hiz_durdur", 32'(durdur), 32'd0);
    end else begin
      timeout  = (lat > ZA);
      n_exp    = timeout ? ZA : lat;
      exp_mask = isStore(op) ? 4'((((1 << sz) - 1) << int'(addr % 4))) : 4'd0;
      exp_data = (sz == 1) ? rs2[7:0] * 32'h01010101 : (sz == 2) ? rs2[15:0] * 32'h00010001 : rs2;
      n = 0;
      while (bellek_istek && n < 50) begin
        n++;
        checkOutput("req_adres", bellek_adres, addr & 32'hFFFF_FFFC);
        checkOutput("req_maske", 32'(bellek_maske), 32'(exp_mask));
        checkOutput("req_yaz", 32'(bellek_yaz), 32'(isStore(op)));
        if (isStore(op)) checkOutput("req_veri", bellek_veri_out, exp_data);
        checkOutput("req_durdur", 32'(durdur), 32'd1);
        giris_gecerli = 1'b1;
        islem_kodu    = ALU_ADD;
        sonuc         = $urandom;
        if (n == lat) begin
          bellek_hazir   = 1'b1;
          bellek_veri_in = word;
        end
        tick();
        bellek_hazir = 1'b0;
      end
      giris_gecerli = 1'b0;
      checkOutput("istek_cycles", 32'(n), 32'(n_exp));
      checkOutput("mem_gecerli", 32'(cikis_gecerli), 32'd1);
      checkOutput("mem_zaman", 32'(zaman_asimi), 32'(timeout));
      checkOutput("mem_hizasiz", 32'(hizasiz), 32'd0);
      checkOutput("mem_yazmac", 32'(cikis_yazmac), 32'(rd));
      checkOutput("mem_durdur", 32'(durdur), 32'd0);
      if (timeout || isStore(op)) begin
        checkOutput("mem_veri", cikis_veri, 32'd0);
        checkOutput("mem_yaz", 32'(cikis_yaz), 32'd0);
      end else begin
        checkOutput("load_veri", cikis_veri, modelLoad(op, addr, word));
        checkOutput("load_yaz", 32'(cikis_yaz), 32'(rd != 0));
      end
    end
    tick();
    checkOutput("pulse_end", 32'(cikis_gecerli), 32'd0);
  endtask

  logic [5:0] op_table [11] = '{ALU_ADD, ALU_XOR, ALU_SLL, MEM_LB, MEM_LH, MEM_LW,
                                MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW};

  initial begin
    rst = 1'b0;
    giris_gecerli = 1'b0; islem_kodu = 6'd0; sonuc = 32'd0; yazmac_degeri2 = 32'd0;
    hedef_yazmac = 5'd0; yazmac_yaz = 1'b0; bellek_hazir = 1'b0; bellek_veri_in = 32'd0;
    repeat (3) tick();
    checkOutput("rst_durdur", 32'(durdur), 32'd0);
    checkOutput("rst_istek", 32'(bellek_istek), 32'd0);
    checkOutput("rst_gecerli", 32'(cikis_gecerli), 32'd0);
    checkOutput("rst_veri", cikis_veri, 32'd0);
    rst = 1'b1;
    tick();

    $display("[TB] directed cases");
    applyStimulus(ALU_ADD, 32'h12345678, 32'd0, 5'd5, 1'b1, 0, 32'd0);
    applyStimulus(ALU_ADD, 32'h12345678, 32'd0, 5'd0, 1'b1, 0, 32'd0);
    applyStimulus(MEM_LB,  32'h00000103, 32'd0, 5'd7, 1'b0, 4, 32'h80FF_0000);
    applyStimulus(MEM_LBU, 32'h00000103, 32'd0, 5'd7, 1'b0, 4, 32'h80FF_0000);
    applyStimulus(MEM_SH,  32'h00000202, 32'hAAAA_BEEF, 5'd3, 1'b1, 2, 32'd0);
    applyStimulus(MEM_LW,  32'h00000101, 32'd0, 5'd9, 1'b1, 1, 32'd0);
    applyStimulus(MEM_LW,  32'h00000400, 32'd0, 5'd9, 1'b1, 100, 32'd0);
    applyStimulus(MEM_LW,  32'h00000400, 32'd0, 5'd9, 1'b1, 1, 32'hCAFE_F00D);

    // Back-to-back pass-through operations
    giris_gecerli = 1'b1; islem_kodu = ALU_XOR; sonuc = 32'h1111_1111; hedef_yazmac = 5'd3; yazmac_yaz = 1'b1;
    tick();
    checkOutput("b2b_first", cikis_veri, 32'h1111_1111);
    sonuc = 32'h2222_2222; hedef_yazmac = 5'd0;
    tick();
    giris_gecerli = 1'b0;
    checkOutput("b2b_second", cikis_veri, 32'h2222_2222);
    checkOutput("b2b_yaz_rd0", 32'(cikis_yaz), 32'd0);
    checkOutput("b2b_gecerli", 32'(cikis_gecerli), 32'd1);
    tick();

    // Reset while a request is outstanding
    giris_gecerli = 1'b1; islem_kodu = MEM_LW; sonuc = 32'h0000_0800; hedef_yazmac = 5'd4;
    tick();
    giris_gecerli = 1'b0;
    checkOutput("pre_rst_istek", 32'(bellek_istek), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("midrst_istek", 32'(bellek_istek), 32'd0);
    checkOutput("midrst_durdur", 32'(durdur), 32'd0);
    checkOutput("midrst_adres", bellek_adres, 32'd0);
    checkOutput("midrst_gecerli", 32'(cikis_gecerli), 32'd0);
    for (int i = 0; i < 5; i++) begin
      bellek_hazir = 1'b1;
      tick();
      checkOutput("postrst_quiet", {30'd0, cikis_gecerli, bellek_istek}, 32'd0);
    end
    bellek_hazir = 1'b0;

    $display("[TB] randomized cases");
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      applyStimulus(op_table[$urandom_range(0, 10)], a, $urandom, 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), $urandom_range(1, ZA + 2), $urandom);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
